// File: rtl/ssd_scan.sv
// rtl/ssd_scan.sv - four-digit multiplexed seven-segment display scanner
//
// Captures four BCD digits plus per-digit decimal points on request and
// drives a common-anode four-digit display by time multiplexing. A
// prescaler divides the clock so each digit slot lasts DIV cycles; a
// one-cycle blank separates slots so no ghosting shows on the next digit.
//
// Ports:
//   ssd_clk    in   single clock, rising edge
//   ssd_rst_n  in   asynchronous active-low reset
//   ssd_load   in   capture ssd_din/ssd_dpin into the snapshot
//   ssd_din    in   [15:0] four BCD digits, [3:0] = digit0 (rightmost)
//   ssd_dpin   in   [3:0] decimal-point request per digit, active-high
//   ssd_ack    out  high the cycle after a capture edge
//   ssd_an     out  [3:0] anode enables, active-low, bit k = digit k
//   ssd_seg    out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   ssd_dp     out  decimal point, active-low
//
// Build option: define SSD_LZB_EN for leading-zero blanking of digits 3..1.

module ssd_scan #(
  parameter int DIV = 50000
) (
  input  logic        ssd_clk,
  input  logic        ssd_rst_n,
  input  logic        ssd_load,
  input  logic [15:0] ssd_din,
  input  logic [3:0]  ssd_dpin,
  output logic        ssd_ack,
  output logic [3:0]  ssd_an,
  output logic [6:0]  ssd_seg,
  output logic        ssd_dp
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // State encoding: bit 2 marks the blank cycle, bits 1:0 name the digit
  // that the state shows (or is about to show, for a blank state).
  localparam logic [2:0] SHOW0  = 3'b000;
  localparam logic [2:0] SHOW1  = 3'b001;
  localparam logic [2:0] SHOW2  = 3'b010;
  localparam logic [2:0] SHOW3  = 3'b011;
  localparam logic [2:0] BLANK0 = 3'b100;
  localparam logic [2:0] BLANK1 = 3'b101;
  localparam logic [2:0] BLANK2 = 3'b110;
  localparam logic [2:0] BLANK3 = 3'b111;

  logic [15:0]   din_q,   din_d;
  logic [3:0]    dpin_q,  dpin_d;
  logic          ack_q,   ack_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    state_q, state_d;
  logic [3:0]    an_q,    an_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;

  logic          tick;
  logic [1:0]    digit;
  logic          blank_slot;
  logic [3:0]    cur_nib;
  logic          lzb;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  // Snapshot and acknowledge
  always_comb begin
    din_d  = din_q;
    dpin_d = dpin_q;
    ack_d  = ssd_load;
    if (ssd_load) begin
      din_d  = ssd_din;
      dpin_d = ssd_dpin;
    end
  end

  // Prescaler: terminal count is the scan tick
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  // Scan FSM. A tick can never land on a blank cycle because the blank
  // follows a tick and DIV >= 2, so blank states leave unconditionally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW0:   if (tick) state_d = BLANK1;
      SHOW1:   if (tick) state_d = BLANK2;
      SHOW2:   if (tick) state_d = BLANK3;
      SHOW3:   if (tick) state_d = BLANK0;
      BLANK0:  state_d = SHOW0;
      BLANK1:  state_d = SHOW1;
      BLANK2:  state_d = SHOW2;
      BLANK3:  state_d = SHOW3;
      default: state_d = SHOW0;
    endcase
  end

  assign digit      = state_q[1:0];
  assign blank_slot = state_q[2];

  always_comb begin
    cur_nib = 4'd0;
    case (digit)
      2'd0: cur_nib = din_q[3:0];
      2'd1: cur_nib = din_q[7:4];
      2'd2: cur_nib = din_q[11:8];
      2'd3: cur_nib = din_q[15:12];
      default: cur_nib = 4'd0;
    endcase
  end

`ifdef SSD_LZB_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit0 always shows so a zero value still reads "0".
  logic zero_3;
  logic zero_32;
  logic zero_321;

  assign zero_3   = (din_q[15:12] == 4'd0);
  assign zero_32  = zero_3  && (din_q[11:8] == 4'd0);
  assign zero_321 = zero_32 && (din_q[7:4]  == 4'd0);

  always_comb begin
    lzb = 1'b0;
    case (digit)
      2'd3: lzb = zero_3;
      2'd2: lzb = zero_32;
      2'd1: lzb = zero_321;
      default: lzb = 1'b0;
    endcase
  end
`else
  assign lzb = 1'b0;
`endif

  // Registered display outputs, derived from the current state and snapshot
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank_slot) begin
      an_d  = ~(4'b0001 << digit);
      seg_d = lzb ? 7'h7F : seg_decode(cur_nib);
      dp_d  = ~dpin_q[digit];
    end
  end

  always_ff @(posedge ssd_clk or negedge ssd_rst_n) begin
    if (!ssd_rst_n) begin
      din_q   <= 16'h0000;
      dpin_q  <= 4'h0;
      ack_q   <= 1'b0;
      presc_q <= '0;
      state_q <= SHOW0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      din_q   <= din_d;
      dpin_q  <= dpin_d;
      ack_q   <= ack_d;
      presc_q <= presc_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign ssd_ack = ack_q;
  assign ssd_an  = an_q;
  assign ssd_seg = seg_q;
  assign ssd_dp  = dp_q;

endmodule

// File: tb/tb_ssd_scan.sv
// tb/tb_ssd_scan.sv - self-checking bench for ssd_scan (DIV=4)

module tb_ssd_scan;

  localparam int DIV = 4;

`ifdef SSD_LZB_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [3:0]  dpin = 4'h0;
  logic        ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail = 0;

  ssd_scan #(.DIV(DIV)) dut (
    .ssd_clk   (clk),
    .ssd_rst_n (rst_n),
    .ssd_load  (load),
    .ssd_din   (din),
    .ssd_dpin  (dpin),
    .ssd_ack   (ack),
    .ssd_an    (an),
    .ssd_seg   (seg),
    .ssd_dp    (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  dpin;
    logic [27:0] segs;  // {d3,d2,d1,d0}
    logic [3:0]  dpn;   // expected ssd_dp per digit
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the display", name);
  endtask

  // Waits for the first cycle of a window showing the given anode pattern.
  task automatic wait_window(input logic [3:0] want, output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = an;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (prev == 4'b1111 && an == want) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
  endtask

  task automatic apply_load(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    chk("ack_idle", {31'd0, ack}, 32'd0);
    din = d;
    dpin = p;
    load = 1'b1;
    @(negedge clk);
    chk("ack_pulse", {31'd0, ack}, 32'd1);
    load = 1'b0;
    @(negedge clk);
    chk("ack_drop", {31'd0, ack}, 32'd0);
  endtask

  // Pushes one expectation per digit, then pops one per displayed window,
  // starting at digit0.
  task automatic check_rotation(input vec_t v);
    logic [3:0] one;
    logic [27:0] s;
    logic [3:0] prev;
    bit started;
    exp_t e;
    int c;
    one = 4'b0001;
    s = v.segs;
    for (int k = 0; k < 4; k++) begin
      e.an  = ~(one << k);
      e.seg = s[k*7 +: 7];
      e.dp  = v.dpn[k];
      sb.push_back(e);
    end
    started = 1'b0;
    prev = an;
    c = 0;
    while (sb.size() > 0 && c < 80) begin
      @(negedge clk);
      c++;
      if (prev == 4'b1111 && an != 4'b1111) begin
        if (!started && an == 4'b1110) started = 1'b1;
        if (started) begin
          e = sb.pop_front();
          chk("rot_an",  {28'd0, an},  {28'd0, e.an});
          chk("rot_seg", {25'd0, seg}, {25'd0, e.seg});
          chk("rot_dp",  {31'd0, dp},  {31'd0, e.dp});
        end
      end
      prev = an;
    end
    if (sb.size() > 0) begin
      timeout("rotation");
      sb.delete();
    end
  endtask

  initial begin
    bit ok;
    logic [3:0] one;
    logic [3:0] exp_an;

    vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h0007, 4'b0000, {Z, Z, Z, 7'h78},             4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, {Z, Z, Z, 7'h40},             4'b1111};
    vecs[3] = '{16'h00A0, 4'b0010, {Z, Z, 7'h3F, 7'h40},         4'b1101};
    vecs[4] = '{16'h9865, 4'b1001, {7'h10, 7'h00, 7'h02, 7'h12}, 4'b0110};
    vecs[5] = '{16'hFB0C, 4'b1111, {7'h3F, 7'h3F, 7'h40, 7'h3F}, 4'b0000};
    vecs[6] = '{16'h0100, 4'b0000, {Z, 7'h79, 7'h40, 7'h40},     4'b1111};

    // Reset state held from time zero
    #12;
    chk("rst_an",  {28'd0, an},  32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp",  {31'd0, dp},  32'd1);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an",  {28'd0, an},  32'hE);
    chk("first_seg", {25'd0, seg}, 32'h40);
    chk("first_dp",  {31'd0, dp},  32'd1);

    // Table-driven load and full rotation
    for (int i = 0; i < 7; i++) begin
      apply_load(vecs[i].din, vecs[i].dpin);
      check_rotation(vecs[i]);
    end

    // Scan timing: 3 cycles per anode, 1 blank, 16-cycle rotation
    apply_load(16'h1234, 4'b0000);
    wait_window(4'b1110, ok);
    if (!ok) timeout("timing_start");
    else begin
      one = 4'b0001;
      for (int j = 0; j < 16; j++) begin
        if (j > 0) @(negedge clk);
        exp_an = (j % 4 == 3) ? 4'b1111 : ~(one << (j / 4));
        chk("timing_an", {28'd0, an}, {28'd0, exp_an});
      end
    end

    // Load mid-window: value changes, scan position does not
    wait_window(4'b1101, ok);
    if (!ok) timeout("midload_start");
    else begin
      chk("midload_old", {25'd0, seg}, 32'h30);
      din = 16'h5678;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("midload_an1",  {28'd0, an},  32'hD);
      chk("midload_seg1", {25'd0, seg}, 32'h30);
      @(negedge clk);
      chk("midload_an2",  {28'd0, an},  32'hD);
      chk("midload_seg2", {25'd0, seg}, 32'h78);
      @(negedge clk);
      chk("midload_gap",  {28'd0, an},  32'hF);
    end

    // Held load keeps ack high
    @(negedge clk);
    din = 16'h1234;
    load = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("ack_held", {31'd0, ack}, 32'd1);
    end

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    load = 1'b0;
    #1;
    chk("arst_an",  {28'd0, an},  32'hF);
    chk("arst_seg", {25'd0, seg}, 32'h7F);
    chk("arst_dp",  {31'd0, dp},  32'd1);
    chk("arst_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_an",  {28'd0, an},  32'hE);
    chk("restart_seg", {25'd0, seg}, 32'h40);
    check_rotation(vecs[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
